// File: rtl/qea_host_sequencer_if.sv
// Host-side streams of the QEA host sequencer: the context word stream in
// and the state-vector result stream out, both valid/ready.
interface qea_host_sequencer_if #(
  parameter int CTX_W = 64,
  parameter int RES_W = 256
);
  logic             ctx_valid;
  logic             ctx_ready;
  logic [CTX_W-1:0] ctx_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_last;
  logic [RES_W-1:0] res_data;

  modport master (output ctx_valid, ctx_data, res_ready,
                  input  ctx_ready, res_valid, res_data, res_last);
  modport slave  (input  ctx_valid, ctx_data, res_ready,
                  output ctx_ready, res_valid, res_data, res_last);
endinterface

// File: rtl/qea_host_sequencer.sv
// Loads QEA context RAM, initialises state RAM to |0..0>, starts the core and
// streams the final state out. Optional macro QEA_HOST_CYCLE_COUNT_EN adds o_exec_cycles.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = DATA_WIDTH*2,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  qea_host_sequencer_if.slave                  host,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
`ifdef QEA_HOST_CYCLE_COUNT_EN
  ,
  output logic [31:0]                          o_exec_cycles
`endif
);
  localparam int RES_W = PE_NUM*STATE_DATA_WIDTH;
  localparam int SAW   = STATE_ADDR_WIDTH;
  localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
  localparam int QW    = MAX_QBIT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_FX = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // |0..0>: amplitude 1.0 (real part, top bits) in the top lane of word 0
  localparam logic [RES_W-1:0] INIT_WORD0 = {ONE_FX, {(RES_W-DATA_WIDTH){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_START, S_WAIT, S_RREQ, S_RWAIT, S_RHOLD, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [QW-1:0]    qbit_q;
  logic [CAW-1:0]   ins_q, ctx_addr_q;
  logic [SAW-1:0]   st_addr_q, last_addr_q, last_addr_calc;
  logic [QW-1:0]    shamt;
  logic [1:0]       wait_cnt_q;
  logic [RES_W-1:0] res_data_q;
  logic             res_last_q;
  logic             ctx_hs, mask_done;

  assign ctx_hs    = (state_q == S_LOAD) && host.ctx_valid;
  assign mask_done = (wait_cnt_q == 2'd2);
  assign shamt     = i_qbit_num - QW'(PE_NUM_WIDTH);
  // Last state address = 2**(q-PE_NUM_WIDTH)-1, saturating at the address width
  assign last_addr_calc = (i_qbit_num <= QW'(PE_NUM_WIDTH)) ? '0 : ~({SAW{1'b1}} << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_run) state_d = (i_ins_num == '0) ? S_INIT : S_LOAD;
      S_LOAD:  if (ctx_hs && ctx_addr_q == ins_q - CAW'(1)) state_d = S_INIT;
      S_INIT:  if (st_addr_q == last_addr_q) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (mask_done && i_qea_complete) state_d = S_RREQ;
      S_RREQ:  state_d = S_RWAIT;
      S_RWAIT: state_d = S_RHOLD;
      S_RHOLD: if (host.res_ready) state_d = res_last_q ? S_DONE : S_RREQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qbit_q      <= '0;
      ins_q       <= '0;
      ctx_addr_q  <= '0;
      st_addr_q   <= '0;
      last_addr_q <= '0;
      wait_cnt_q  <= '0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_run) begin
          qbit_q      <= i_qbit_num;
          ins_q       <= i_ins_num;
          last_addr_q <= last_addr_calc;
          ctx_addr_q  <= '0;
          st_addr_q   <= '0;
        end
        S_LOAD:  if (ctx_hs) ctx_addr_q <= ctx_addr_q + CAW'(1);
        S_INIT:  st_addr_q <= (st_addr_q == last_addr_q) ? '0 : st_addr_q + SAW'(1);
        S_START: wait_cnt_q <= '0;
        S_WAIT:  if (!mask_done) wait_cnt_q <= wait_cnt_q + 2'd1;
        S_RWAIT: begin
          res_data_q <= i_qea_state_dout;
          res_last_q <= (st_addr_q == last_addr_q);
        end
        S_RHOLD: if (host.res_ready) st_addr_q <= st_addr_q + SAW'(1);
        default: ;
      endcase
    end
  end

`ifdef QEA_HOST_CYCLE_COUNT_EN
  logic [31:0] exec_q;
  // Only unmasked WAIT cycles count, including the one that sees completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              exec_q <= '0;
    else if (state_q == S_START)             exec_q <= '0;
    else if (state_q == S_WAIT && mask_done) exec_q <= exec_q + 32'd1;
  end
  assign o_exec_cycles = exec_q;
`endif

  always_comb begin
    host.ctx_ready = 1'b0;
    host.res_valid = 1'b0;
    host.res_data  = res_data_q;
    host.res_last  = res_last_q;
    o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    o_done         = (state_q == S_DONE);
    o_qea_start    = (state_q == S_START);
    o_qea_qbit_num = qbit_q;
    o_ctx_en       = ctx_hs;
    o_ctx_wea      = ctx_hs;
    o_ctx_addr     = ctx_hs ? ctx_addr_q : '0;
    o_ctx_data     = ctx_hs ? host.ctx_data : '0;
    o_state_ena    = '0;
    o_state_wea    = '0;
    o_state_addra  = '0;
    o_state_dina   = '0;
    unique case (state_q)
      S_LOAD:  host.ctx_ready = 1'b1;
      S_INIT: begin
        o_state_ena   = '1;
        o_state_wea   = '1;
        o_state_addra = st_addr_q;
        o_state_dina  = (st_addr_q == '0) ? INIT_WORD0 : '0;
      end
      S_RREQ: begin
        o_state_ena   = '1;
        o_state_addra = st_addr_q;
      end
      S_RHOLD: host.res_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_qea_host_sequencer.sv
// Bench for qea_host_sequencer: a small QEA RAM/core model plus a result scoreboard
// filled with expected state words when each run is issued.
module tb_qea_host_sequencer;
  typedef struct {
    logic [255:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         i_run = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [15:0]  i_ins_num = '0;
  logic         o_busy, o_done, o_qea_start, o_ctx_en, o_ctx_wea;
  logic [5:0]   o_qea_qbit_num;
  logic [15:0]  o_ctx_addr, o_state_addra;
  logic [63:0]  o_ctx_data;
  logic [3:0]   o_state_ena, o_state_wea;
  logic [255:0] o_state_dina, qdout;
  logic         i_qea_complete;
`ifdef QEA_HOST_CYCLE_COUNT_EN
  logic [31:0]  o_exec_cycles;
`endif

  qea_host_sequencer_if #(.CTX_W(64), .RES_W(256)) hif ();

  qea_host_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .host(hif), .o_busy(o_busy), .o_done(o_done), .o_qea_start(o_qea_start),
    .o_qea_qbit_num(o_qea_qbit_num), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
    .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(qdout)
`ifdef QEA_HOST_CYCLE_COUNT_EN
    , .o_exec_cycles(o_exec_cycles)
`endif
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_word(int a);
    return (a == 0) ? {64'h40000000_00000000, 192'h0} : 256'h0;
  endfunction

  // what the model "computes" on top of the initialised state
  function automatic logic [255:0] pat(int a);
    logic [63:0] x;
    x = 64'(a);
    return {x * 64'd3 + 64'd1, x ^ 64'h1234_5678_9abc_def0, x << 8, ~x};
  endfunction

  // QEA model: state RAM with 1-cycle read, transform + delayed complete after start
  logic [255:0] mem [0:255];
  int  cyc = 0, cmp_cnt = 0, cmp_dly = 5;
  bit  stale = 1'b0, rdy_tog = 1'b0;
  assign i_qea_complete = stale || (cmp_cnt != 0 && cmp_cnt >= cmp_dly);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_state_ena == 4'hf && o_state_wea == 4'hf) mem[o_state_addra[7:0]] <= o_state_dina;
    if (o_state_ena == 4'hf && o_state_wea == 4'h0) qdout <= mem[o_state_addra[7:0]];
    if (!rst_n || o_done) cmp_cnt <= 0;
    else if (o_qea_start) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem[i] ^ pat(i);
      cmp_cnt <= 1;
    end else if (cmp_cnt != 0 && cmp_cnt < 1000) cmp_cnt <= cmp_cnt + 1;
  end

  initial begin
    hif.res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      hif.res_ready = rdy_tog ? !hif.res_ready : 1'b1;
    end
  end

  exp_t exp_q[$];
  int ctx_wr_cnt = 0, init_cnt = 0, init_seq = 0, start_cnt = 0, res_cnt = 0, done_cnt = 0;
  int last_init_cyc = 0, start_cyc = 0, first_rd_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  bit hold_pend = 1'b0;
  logic [255:0] held_data;
  logic held_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ctx_en) ctx_wr_cnt++;
      if (o_state_ena == 4'hf && o_state_wea == 4'hf) begin
        chk("init_addr", 256'(o_state_addra), 256'(init_seq));
        chk("init_data", o_state_dina, init_word(int'(o_state_addra)));
        init_cnt++; init_seq++; last_init_cyc = cyc;
      end
      if (o_state_ena == 4'hf && o_state_wea == 4'h0 && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (o_qea_start) begin start_cnt++; start_cyc = cyc; first_rd_cyc = -1; init_seq = 0; end
      if (hold_pend && hif.res_valid) begin
        chk("res_hold_data", hif.res_data, held_data);
        chk("res_hold_last", 256'(hif.res_last), 256'(held_last));
      end
      hold_pend = hif.res_valid && !hif.res_ready;
      held_data = hif.res_data;
      held_last = hif.res_last;
      if (hif.res_valid && hif.res_ready) begin
        chk("res_avail", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_data", hif.res_data, e.data);
          chk("res_last", 256'(hif.res_last), 256'(e.last));
        end
        res_cnt++; last_hs_cyc = cyc;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, 256'({o_busy, o_done, o_qea_start, o_qea_qbit_num, o_ctx_en, o_ctx_wea,
        hif.ctx_ready, hif.res_valid, hif.res_last, o_state_ena, o_state_wea}), 256'(0));
    chk({tag, "_addr"}, 256'({o_ctx_addr, o_state_addra}), 256'(0));
    chk({tag, "_ctxd"}, 256'(o_ctx_data), 256'(0));
    chk({tag, "_dina"}, o_state_dina, 256'(0));
    chk({tag, "_resd"}, hif.res_data, 256'(0));
`ifdef QEA_HOST_CYCLE_COUNT_EN
    chk({tag, "_exec"}, 256'(o_exec_cycles), 256'(0));
`endif
  endtask

  task automatic do_run(input int q, input int ins, input bit gaps, input bit tog,
                        input bit stl, input bit poke, input int abort_after);
    int n, k, budget, c0, i0, s0, r0, d0;
    bit seen;
    logic [63:0] w;
    n = (q <= 2) ? 1 : (1 << (q - 2));
    c0 = ctx_wr_cnt; i0 = init_cnt; s0 = start_cnt; r0 = res_cnt; d0 = done_cnt;
    for (int a = 0; a < n; a++) exp_q.push_back('{data: init_word(a) ^ pat(a), last: (a == n - 1)});
    rdy_tog = tog; stale = stl;
    @(posedge clk); #1;
    i_run = 1'b1; i_qbit_num = 6'(q); i_ins_num = 16'(ins);
    @(posedge clk); #1;
    i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    k = 0; budget = 4 * ins + 10;
    while (k < ins && budget > 0 && !(abort_after > 0 && k == abort_after)) begin
      hif.ctx_valid = gaps ? (budget % 2 == 0) : 1'b1;
      w = {$urandom, $urandom};
      hif.ctx_data = w;
      @(negedge clk);
      if (hif.ctx_valid) begin
        chk("ctx_en", 256'({o_ctx_en, o_ctx_wea}), 256'(3));
        chk("ctx_addr", 256'(o_ctx_addr), 256'(k));
        chk("ctx_data", 256'(o_ctx_data), 256'(w));
        k++;
      end else chk("ctx_stall_en", 256'(o_ctx_en), 256'(0));
      @(posedge clk); #1;
      budget--;
    end
    if (abort_after > 0) begin
      rst_n = 1'b0; #1;
      chk_outs_zero("abort");
      exp_q.delete();
      @(posedge clk); #1;
      hif.ctx_valid = 1'b0; rst_n = 1'b1;
      chk("abort_ctx_cnt", 256'(ctx_wr_cnt - c0), 256'(abort_after));
      return;
    end
    hif.ctx_valid = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1; i_run = 1'b1; i_qbit_num = 6'd6; i_ins_num = 16'd5;
      @(negedge clk);
      chk("poke_busy", 256'(o_busy), 256'(1));
      @(posedge clk); #1; i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    end
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(posedge clk);
      seen = (done_cnt != d0);
    end
    chk("done_seen", 256'(seen), 256'(1));
    @(negedge clk);
    chk("done_pulse", 256'({o_done, o_busy}), 256'(0));
    chk("ctx_writes", 256'(ctx_wr_cnt - c0), 256'(ins));
    chk("init_writes", 256'(init_cnt - i0), 256'(n));
    chk("starts", 256'(start_cnt - s0), 256'(1));
    chk("start_after_init", 256'(start_cyc), 256'(last_init_cyc + 1));
    chk("results", 256'(res_cnt - r0), 256'(n));
    chk("done_after_last", 256'(done_cyc), 256'(last_hs_cyc + 1));
    chk("sb_empty", 256'(exp_q.size()), 256'(0));
    rdy_tog = 1'b0; stale = 1'b0;
  endtask

  initial begin
    hif.ctx_valid = 1'b0;
    hif.ctx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst_n = 1'b1;

    do_run(6, 183, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    cmp_dly = 40;
    do_run(6, 183, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef QEA_HOST_CYCLE_COUNT_EN
    chk("exec_cycles", 256'(o_exec_cycles), 256'(38));
    repeat (5) @(negedge clk);
    chk("exec_hold", 256'(o_exec_cycles), 256'(38));
`endif

    cmp_dly = 5;
    do_run(4, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("stale_mask", 256'(first_rd_cyc - start_cyc), 256'(4));

    do_run(6, 10, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    do_run(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("qbit_reg", 256'(o_qea_qbit_num), 256'(2));
    repeat (5) @(negedge clk);
    chk("idle_after_poke", 256'({o_busy, hif.ctx_ready, o_state_ena}), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
